// File: rtl/reaction_game_ctrl_pkg.sv
// game_pkg: shared state encoding, display codes and LFSR taps for the reaction game.
package game_pkg;
    typedef enum logic [1:0] {START = 2'd0, READY = 2'd1, PLAY = 2'd2, FINISH = 2'd3} state_t;
    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_FALSE = 4'hE;
    // x^8 + x^6 + x^5 + x^4 + 1, maximal length so a non-zero seed never reaches zero
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/reaction_game_ctrl_bcd2_counter.sv
// bcd2_counter: two-digit BCD up-counter with clear, increment enable and saturation at 99.
module bcd2_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [3:0] tens_nx_o,
    output logic [3:0] ones_nx_o,
    output logic       sat_o
);
    logic [3:0] tens_q, ones_q;
    assign sat_o = (tens_q == 4'd9) && (ones_q == 4'd9);
    always_comb begin
        tens_nx_o = tens_q;
        ones_nx_o = ones_q;
        if (clr_i) begin
            tens_nx_o = 4'd0;
            ones_nx_o = 4'd0;
        end else if (inc_i && !sat_o) begin
            ones_nx_o = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
            tens_nx_o = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_nx_o;
            ones_q <= ones_nx_o;
        end
    end
    assign tens_o = tens_q;
    assign ones_o = ones_q;
endmodule

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: button sync, LFSR pre-start delay and BCD reaction timer FSM.
// Define BEST_SCORE_EN to keep a best-score register shown while in START.
module reaction_game_ctrl
    import game_pkg::*;
#(
    parameter int          MIN_DELAY = 10,
    parameter int          RAND_BITS = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       go_led,
    output logic [1:0] state,
    output logic       done
);
    state_t     state_q, state_d;
    logic [2:0] sync_q;
    logic [7:0] lfsr_q, delay_q, delay_d;
    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic       go_q, done_q, press, inc, sat;
    logic [3:0] cnt_tens, cnt_ones, cnt_tens_nx, cnt_ones_nx;
    logic [7:0] start_dig;

    assign press = sync_q[1] & ~sync_q[2];

    bcd2_counter u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != PLAY),
        .inc_i     (inc),
        .tens_o    (cnt_tens),
        .ones_o    (cnt_ones),
        .tens_nx_o (cnt_tens_nx),
        .ones_nx_o (cnt_ones_nx),
        .sat_o     (sat)
    );

`ifdef BEST_SCORE_EN
    logic [7:0] best_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) best_q <= 8'h99;
        else if (state_q == PLAY && press && {cnt_tens, cnt_ones} < best_q) best_q <= {cnt_tens, cnt_ones};
    end
    assign start_dig = best_q;
`else
    assign start_dig = {DIG_BLANK, DIG_BLANK};
`endif

    // press has priority over tick in every state
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        inc     = 1'b0;
        unique case (state_q)
            START: begin
                {tens_d, ones_d} = press ? {DIG_BLANK, DIG_BLANK} : start_dig;
                if (press) begin
                    state_d = READY;
                    delay_d = 8'(MIN_DELAY) + 8'(lfsr_q[RAND_BITS-1:0]);
                end
            end
            READY: begin
                if (press) begin
                    state_d = FINISH;
                    tens_d  = DIG_FALSE;
                    ones_d  = DIG_FALSE;
                end else if (tick) begin
                    delay_d = delay_q - 8'd1;
                    if (delay_q == 8'd1) begin
                        state_d = PLAY;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                    end
                end
            end
            PLAY: begin
                inc    = tick && !press;
                tens_d = cnt_tens_nx;
                ones_d = cnt_ones_nx;
                if (press || (tick && sat)) state_d = FINISH;
            end
            FINISH: begin
                if (press) begin
                    state_d = START;
                    tens_d  = DIG_BLANK;
                    ones_d  = DIG_BLANK;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START;
            sync_q  <= 3'b000;
            lfsr_q  <= LFSR_SEED;
            delay_q <= 8'd0;
            tens_q  <= DIG_BLANK;
            ones_q  <= DIG_BLANK;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], btn};
            lfsr_q  <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
            delay_q <= delay_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            go_q    <= state_d == PLAY;
            done_q  <= state_d == FINISH && state_q != FINISH;
        end
    end

    assign state  = state_q;
    assign tens   = tens_q;
    assign ones   = ones_q;
    assign go_led = go_q;
    assign done   = done_q;
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb_reaction_game_ctrl: table-driven game rounds with a done-event scoreboard.
module tb_reaction_game_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, btn = 1'b0;
    logic [3:0] tens, ones;
    logic       go_led, done;
    logic [1:0] state;
    logic [7:0] m_lfsr;
    logic [7:0] exp_q[$], obs_q[$];
    int         n_tests = 0, n_fail = 0, go_cnt = 0;

    typedef struct {
        string      name;
        int         ready_ticks;
        int         play_ticks;
        bit         press_play;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[7];

    reaction_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn),
        .tens(tens), .ones(ones), .go_led(go_led), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 8'hA5;
        else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    always @(negedge clk) begin
        if (done) obs_q.push_back({tens, ones});
        if (go_led) go_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic press_btn();
        btn = 1'b1;
        cyc(3);
        btn = 1'b0;
        cyc(2);
    endtask

    task automatic go_to_play(input string name);
        int dly;
        btn = 1'b1;
        cyc(2);
        dly = 10 + int'(m_lfsr[3:0]);
        chk({name, " latency2"}, state, 0);
        cyc(1);
        chk({name, " latency3"}, state, 1);
        btn = 1'b0;
        cyc(2);
        repeat (dly - 1) pulse_tick();
        chk({name, " ready_hold"}, state, 1);
        pulse_tick();
        chk({name, " play_state"}, state, 2);
        chk({name, " play_led"}, go_led, 1);
        chk({name, " play_digits"}, {tens, ones}, 8'h00);
    endtask

    task automatic sb_check(input string name);
        logic [7:0] e;
        int n;
        n = obs_q.size();
        chk({name, " done_pulses"}, n, 1);
        e = exp_q.pop_front();
        if (n > 0) chk({name, " result"}, obs_q[0], e);
        obs_q.delete();
    endtask

    initial begin
        vecs[0] = '{"play37",  -1,  37, 1'b1, 8'h37};
        vecs[1] = '{"play0",   -1,   0, 1'b1, 8'h00};
        vecs[2] = '{"carry9",  -1,   9, 1'b1, 8'h09};
        vecs[3] = '{"carry10", -1,  10, 1'b1, 8'h10};
        vecs[4] = '{"false3",   3,   0, 1'b1, 8'hEE};
        vecs[5] = '{"play99",  -1,  99, 1'b1, 8'h99};
        vecs[6] = '{"tmo100",  -1, 100, 1'b0, 8'h99};

        cyc(3);
        rst_n = 1'b1;
        cyc(50);
        chk("idle state", state, 0);
        chk("idle digits", {tens, ones}, 8'hFF);
        chk("idle led", go_led, 0);
        chk("idle done", done, 0);
        pulse_tick();
        chk("start tick ignored", state, 0);

        for (int i = 0; i < 7; i++) begin
            int go0;
            exp_q.push_back(vecs[i].exp);
            if (vecs[i].ready_ticks >= 0) begin
                go0 = go_cnt;
                press_btn();
                chk({vecs[i].name, " ready"}, state, 1);
                repeat (vecs[i].ready_ticks) pulse_tick();
                press_btn();
                chk({vecs[i].name, " no_go"}, go_cnt - go0, 0);
            end else begin
                go_to_play(vecs[i].name);
                for (int k = 0; k < vecs[i].play_ticks; k++) begin
                    pulse_tick();
                    if (!vecs[i].press_play && k == vecs[i].play_ticks - 2)
                        chk({vecs[i].name, " still_play"}, state, 2);
                end
                if (vecs[i].press_play) press_btn();
            end
            chk({vecs[i].name, " finish"}, state, 3);
            chk({vecs[i].name, " led_off"}, go_led, 0);
            sb_check(vecs[i].name);
            repeat (3) pulse_tick();
            chk({vecs[i].name, " held"}, {tens, ones}, vecs[i].exp);
            chk({vecs[i].name, " single_done"}, obs_q.size(), 0);
            press_btn();
            chk({vecs[i].name, " back_start"}, state, 0);
            chk({vecs[i].name, " blank"}, {tens, ones}, 8'hFF);
        end

        go_to_play("tie");
        repeat (42) pulse_tick();
        exp_q.push_back(8'h42);
        btn = 1'b1;
        cyc(2);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        btn = 1'b0;
        cyc(2);
        chk("tie finish", state, 3);
        sb_check("tie");
        btn = 1'b1;
        cyc(20);
        btn = 1'b0;
        cyc(2);
        chk("held btn one press", state, 0);

        go_to_play("rst");
        repeat (5) pulse_tick();
        rst_n = 1'b0;
        #2;
        chk("async rst state", state, 0);
        chk("async rst digits", {tens, ones}, 8'hFF);
        chk("async rst led", go_led, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("rst no done", obs_q.size(), 0);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
